rom_burst_reader: RTL and testbench

Parametrised synchronous ROM with a burst read engine. It is the successor to the fixed 4x4 ROM and is generalised in data width and depth. It adds a start/busy handshake, multi-word bursts with optional address wrap, a stall enable, and an out-of-range error flag. It sits as a constant/coefficient source feeding downstream datapath blocks that consume one word per cycle qualified by `valid`.

---
 rtl/rom_burst_reader.sv | 98 +++++++++
 tb/tb_rom_burst_reader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_burst_reader.sv
// Parametrised constant ROM with a burst read engine. It supports start/busy handshake,
// wrap or truncate at the top address, stall enable and a truncation error flag.
module rom_burst_reader #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] burst_len,
  input  logic              wrap,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              last,
  output logic              err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, READ} state_t;

  // NOTE: the ROM is elaboration-time constant wiring, so it has no reset and no storage.
  logic [DATA_W-1:0] mem [DEPTH];
  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    assign mem[i] = DATA_W'(5 * i + 3);
  end

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              trunc_q, trunc_d;
  logic [DATA_W-1:0] data_d;
  logic              valid_d, last_d, err_d;
  logic              final_word;
  logic [ADDR_W:0]   end_addr;

  // Evaluated one bit wider so an overflow past the top address is visible.
  assign end_addr   = {1'b0, start_addr} + {1'b0, burst_len};
  assign final_word = (cnt_q == '0) || (trunc_q && (ptr_q == {ADDR_W{1'b1}}));
  assign busy       = (state_q == READ);

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    trunc_d = trunc_q;
    data_d  = data_out;
    valid_d = 1'b0;
    last_d  = 1'b0;
    err_d   = 1'b0;
    if (state_q == IDLE) begin
      if (en && start) begin
        ptr_d   = start_addr;
        cnt_d   = burst_len;
        trunc_d = !wrap && (end_addr > (ADDR_W + 1)'(DEPTH - 1));
        state_d = READ;
      end
    end else if (en) begin
      data_d  = mem[ptr_q];
      valid_d = 1'b1;
      ptr_d   = ptr_q + ADDR_W'(1);
      cnt_d   = cnt_q - ADDR_W'(1);
      if (final_word) begin
        last_d  = 1'b1;
        err_d   = trunc_q;
        state_d = IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      trunc_q  <= 1'b0;
      data_out <= '0;
      valid    <= 1'b0;
      last     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      trunc_q  <= trunc_d;
      data_out <= data_d;
      valid    <= valid_d;
      last     <= last_d;
      err      <= err_d;
    end
  end

endmodule

// File: tb/tb_rom_burst_reader.sv
// Self-checking bench for rom_burst_reader: directed table, corner sequences and
// randomized bursts with stalls checked against an address-list reference model.
module tb_rom_burst_reader;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0, start = 1'b0, wrap = 1'b0;
  logic [1:0] start_addr = '0, burst_len = '0;
  logic       busy, valid, last, err;
  logic [3:0] data_out;

  logic       en8 = 1'b1, start8 = 1'b0, wrap8 = 1'b0;
  logic [2:0] addr8 = '0, len8 = '0;
  logic       busy8, valid8, last8, err8;
  logic [7:0] data8;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] last_data = '0;
  logic [3:0] exp_q[$];
  bit         exp_tr;

  typedef struct {
    logic [1:0]  addr;
    logic [1:0]  len;
    logic        wrap;
    int          n;
    logic [15:0] w;    // word k in nibble k
    bit          err;
  } vec_t;

  vec_t tbl[6];

  rom_burst_reader dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .start_addr(start_addr),
    .burst_len(burst_len), .wrap(wrap), .busy(busy), .data_out(data_out),
    .valid(valid), .last(last), .err(err)
  );

  rom_burst_reader #(.DATA_W(8), .ADDR_W(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .start(start8), .start_addr(addr8),
    .burst_len(len8), .wrap(wrap8), .busy(busy8), .data_out(data8),
    .valid(valid8), .last(last8), .err(err8)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input string name, input logic [3:0] w, input bit is_last,
                             input bit is_err);
    check({name, ".valid"}, 32'(valid), 32'd1);
    check({name, ".data"}, 32'(data_out), 32'(w));
    check({name, ".last"}, 32'(last), 32'(is_last));
    check({name, ".err"}, 32'(err), 32'(is_err));
    last_data = w;
  endtask

  task automatic expect_quiet(input string name);
    check({name, ".valid"}, 32'(valid), 32'd0);
    check({name, ".last"}, 32'(last), 32'd0);
    check({name, ".err"}, 32'(err), 32'd0);
    check({name, ".data_hold"}, 32'(data_out), 32'(last_data));
  endtask

  // Reference: the burst is the list of addresses start..start+len, cut at DEPTH-1
  // when not wrapping; each word is (5*a+3) mod 16.
  task automatic model_burst(input int a, input int l, input bit w);
    exp_q.delete();
    exp_tr = 1'b0;
    for (int k = 0; k <= l; k++) begin
      if (!w && (a + k) > DEPTH - 1) begin
        exp_tr = 1'b1;
        break;
      end
      exp_q.push_back(4'((5 * ((a + k) % DEPTH) + 3) % 16));
    end
  endtask

  // Runs one burst from IDLE against exp_q/exp_tr with optional stalls and start noise.
  task automatic run_burst(input string name, input logic [1:0] a, input logic [1:0] l,
                           input logic w, input int stall_pct, input bit noise);
    int idx = 0;
    int cycles = 0;
    int n = exp_q.size();
    start_addr = a; burst_len = l; wrap = w; en = 1'b1; start = 1'b1;
    tick();
    check({name, ".busy_start"}, 32'(busy), 32'd1);
    check({name, ".no_early_valid"}, 32'(valid), 32'd0);
    start = 1'b0;
    while (idx < n && cycles < 64) begin
      en = ($urandom_range(0, 99) >= stall_pct);
      if (noise) begin
        start      = 1'($urandom_range(0, 1));
        start_addr = 2'($urandom);
        burst_len  = 2'($urandom);
        wrap       = 1'($urandom);
      end
      tick();
      cycles++;
      if (en) begin
        expect_word(name, exp_q[idx], idx == n - 1, exp_tr && (idx == n - 1));
        idx++;
      end else begin
        expect_quiet({name, ".stall"});
      end
      check({name, ".busy"}, 32'(busy), 32'(idx < n));
    end
    if (idx < n) check({name, ".timeout"}, idx, n);
    start = 1'b0; en = 1'b1;
    tick();
    expect_quiet({name, ".idle"});
    check({name, ".idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int busy_cycles;

    tbl[0] = '{addr: 2'd0, len: 2'd0, wrap: 1'b0, n: 1, w: 16'h0003, err: 1'b0};
    tbl[1] = '{addr: 2'd1, len: 2'd0, wrap: 1'b0, n: 1, w: 16'h0008, err: 1'b0};
    tbl[2] = '{addr: 2'd2, len: 2'd0, wrap: 1'b0, n: 1, w: 16'h000D, err: 1'b0};
    tbl[3] = '{addr: 2'd3, len: 2'd0, wrap: 1'b0, n: 1, w: 16'h0002, err: 1'b0};
    tbl[4] = '{addr: 2'd2, len: 2'd3, wrap: 1'b1, n: 4, w: 16'h832D, err: 1'b0};
    tbl[5] = '{addr: 2'd2, len: 2'd3, wrap: 1'b0, n: 2, w: 16'h002D, err: 1'b1};

    // Reset, with a start already pending for the first edge after release.
    #2 rst_n = 1'b0;
    en = 1'b1; start = 1'b1; start_addr = 2'd0; burst_len = 2'd0; wrap = 1'b0;
    #5;
    check("reset.busy", 32'(busy), 32'd0);
    expect_quiet("reset");
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("release.busy", 32'(busy), 32'd1);
    start = 1'b0;
    tick();
    expect_word("release.word", 4'd3, 1'b1, 1'b0);
    tick();
    expect_quiet("release.idle");

    // Directed table: singles, wrapping and truncated bursts.
    foreach (tbl[i]) begin
      exp_q.delete();
      for (int k = 0; k < tbl[i].n; k++) exp_q.push_back(tbl[i].w[4*k +: 4]);
      exp_tr = tbl[i].err;
      run_burst($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].len, tbl[i].wrap, 0, 1'b0);
    end

    // Stall: en low for two cycles after the second word.
    busy_cycles = 0;
    start_addr = 2'd0; burst_len = 2'd3; wrap = 1'b1; en = 1'b1; start = 1'b1;
    tick(); busy_cycles += int'(busy); start = 1'b0;
    tick(); busy_cycles += int'(busy); expect_word("stall.w0", 4'd3, 1'b0, 1'b0);
    tick(); busy_cycles += int'(busy); expect_word("stall.w1", 4'd8, 1'b0, 1'b0);
    en = 1'b0;
    tick(); busy_cycles += int'(busy); expect_quiet("stall.s0");
    tick(); busy_cycles += int'(busy); expect_quiet("stall.s1");
    en = 1'b1;
    tick(); busy_cycles += int'(busy); expect_word("stall.w2", 4'd13, 1'b0, 1'b0);
    tick(); busy_cycles += int'(busy); expect_word("stall.w3", 4'd2, 1'b1, 1'b0);
    check("stall.busy_cycles", busy_cycles, 6);
    tick();

    // Start ignored mid-burst and on the last edge, accepted on the next edge.
    start_addr = 2'd0; burst_len = 2'd3; wrap = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    tick(); expect_word("b2b.w0", 4'd3, 1'b0, 1'b0);
    start = 1'b1; start_addr = 2'd3;
    tick(); expect_word("b2b.w1", 4'd8, 1'b0, 1'b0);
    start = 1'b0;
    tick(); expect_word("b2b.w2", 4'd13, 1'b0, 1'b0);
    start = 1'b1; start_addr = 2'd1; burst_len = 2'd0;
    tick(); expect_word("b2b.w3", 4'd2, 1'b1, 1'b0);
    check("b2b.last_edge_busy", 32'(busy), 32'd0);
    tick();
    check("b2b.accept_busy", 32'(busy), 32'd1);
    expect_quiet("b2b.gap");
    start = 1'b0;
    tick(); expect_word("b2b.new", 4'd8, 1'b1, 1'b0);

    // Asynchronous reset mid-burst.
    start_addr = 2'd0; burst_len = 2'd3; wrap = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    tick(); expect_word("mrst.w0", 4'd3, 1'b0, 1'b0);
    tick(); expect_word("mrst.w1", 4'd8, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    last_data = '0;
    check("mrst.busy", 32'(busy), 32'd0);
    expect_quiet("mrst");
    @(negedge clk) rst_n = 1'b1;
    model_burst(1, 1, 1'b0);
    run_burst("mrst.after", 2'd1, 2'd1, 1'b0, 0, 1'b0);

    // Wider instance: mem[7] = 38, and a truncated burst from address 6.
    addr8 = 3'd7; len8 = 3'd0; wrap8 = 1'b0; start8 = 1'b1;
    tick(); start8 = 1'b0;
    tick();
    check("w8.mem7", 32'(data8), 32'd38);
    check("w8.last", 32'({valid8, last8, err8}), 32'b110);
    tick();
    addr8 = 3'd6; len8 = 3'd3; start8 = 1'b1;
    tick(); start8 = 1'b0;
    tick(); check("w8.t0", 32'({valid8, last8, err8, data8}), {3'b100, 8'd33});
    tick(); check("w8.t1", 32'({valid8, last8, err8, data8}), {3'b111, 8'd38});
    check("w8.idle", 32'(busy8), 32'd0);

    // Randomized bursts with stalls and start noise.
    for (int r = 0; r < 40; r++) begin
      logic [1:0] a = 2'($urandom);
      logic [1:0] l = 2'($urandom);
      logic       w = 1'($urandom);
      model_burst(int'(a), int'(l), w);
      run_burst($sformatf("rnd%0d", r), a, l, w, 25, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
